// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-enable input and timing outputs of the VGA timing
// generator, bundled for connection between the generator (master) and
// its consumer (slave).
interface vga_timing_if;
  logic       pix_en;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  pix_en,
    output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical pixel counters with registered sync,
// visible-area and line/frame start flags, all aligned to the position
// they describe. Define VGA_FRAME_COUNT_EN to enable frame_start and the
// 8-bit completed-frame counter; otherwise both outputs are tied to 0.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master bus
);

  localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       visible_q, visible_d;
  logic       line_start_q, line_start_d;
  logic       frame_wrap;

  // Next position and the flags describing it, so the registered flags line
  // up with the registered position without a combinational path from pix_en.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    hpos_d     = hpos_q + 10'd1;
    vpos_d     = vpos_q;
    frame_wrap = 1'b0;
    if (hpos_q == H_LAST) begin
      hpos_d = 10'd0;
      if (vpos_q == V_LAST) begin
        vpos_d     = 10'd0;
        frame_wrap = 1'b1;
      end else begin
        vpos_d = vpos_q + 10'd1;
      end
    end
    hsync_d      = !((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST));
    vsync_d      = !((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST));
    visible_d    = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    line_start_d = (hpos_d == 10'd0);
  end

  // Position and flag registers: synchronous reset to the (0,0) state, step on pix_en.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    if (!rst_n) begin
      hpos_q       <= 10'd0;
      vpos_q       <= 10'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      visible_q    <= 1'b1;
      line_start_q <= 1'b1;
    end else if (bus.pix_en) begin
      hpos_q       <= hpos_d;
      vpos_q       <= vpos_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      visible_q    <= visible_d;
      line_start_q <= line_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic       frame_start_q;
  logic [7:0] frame_count_q;

  // Frame start flag and completed-frame counter, advanced on the frame wrap step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start_q <= 1'b1;
      frame_count_q <= 8'd0;
    end else if (bus.pix_en) begin
      frame_start_q <= line_start_d && (vpos_d == 10'd0);
      if (frame_wrap) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
  assign bus.frame_start   = 1'b0;
  assign bus.frame_count   = 8'd0;
`endif

  assign bus.hpos       = hpos_q;
  assign bus.vpos       = vpos_q;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.visible    = visible_q;
  assign bus.line_start = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-size instance for one-line timing, plus a
// reduced-size instance (16x8 totals) for table vectors, randomized
// stimulus against an arithmetic reference model, and frame-counter wrap.
module tb_vga_timing_gen;

  // Reduced geometry: H 8+2+3+3=16, V 4+1+2+1=8, 128 steps per frame.
  localparam int HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic clk = 1'b0;
  logic rst_n_def;
  logic rst_n_sml;

  vga_timing_if if_def ();
  vga_timing_if if_sml ();

  vga_timing_gen u_def (
    .clk   (clk),
    .rst_n (rst_n_def),
    .bus   (if_def)
  );

  vga_timing_gen #(
    .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) u_sml (
    .clk   (clk),
    .rst_n (rst_n_sml),
    .bus   (if_sml)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int h, v;
    bit hs, vs, vis, ls, fs;
    int fc;
  } exp_t;

  typedef struct {
    bit rst_n;
    bit pe;
    int ncyc;
    int h, v;
    bit hs, vs, vis, ls;
    int fc;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Edge, then sample 1 time unit later, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: position after n pixel steps since reset, by plain arithmetic.
  function automatic exp_t model(input int n);
    exp_t e;
    e.h   = n % HT;
    e.v   = (n / HT) % VT;
    e.hs  = !(e.h >= HD + HF && e.h < HD + HF + HS);
    e.vs  = !(e.v >= VD + VF && e.v < VD + VF + VS);
    e.vis = (e.h < HD) && (e.v < VD);
    e.ls  = (e.h == 0);
`ifdef VGA_FRAME_COUNT_EN
    e.fs  = (e.h == 0) && (e.v == 0);
    e.fc  = (n / (HT * VT)) % 256;
`else
    e.fs  = 1'b0;
    e.fc  = 0;
`endif
    return e;
  endfunction

  task automatic compare_sml(input string tag, input exp_t e);
    check({tag, ".hpos"},        if_sml.hpos,        e.h);
    check({tag, ".vpos"},        if_sml.vpos,        e.v);
    check({tag, ".hsync"},       if_sml.hsync,       e.hs);
    check({tag, ".vsync"},       if_sml.vsync,       e.vs);
    check({tag, ".visible"},     if_sml.visible,     e.vis);
    check({tag, ".line_start"},  if_sml.line_start,  e.ls);
    check({tag, ".frame_start"}, if_sml.frame_start, e.fs);
    check({tag, ".frame_count"}, if_sml.frame_count, e.fc);
  endtask

  vec_t vecs[22];

  initial begin
    int hs_low, hs_first, vis_low, vs_low;
    int n;
    exp_t e;

    rst_n_def = 1'b0;
    rst_n_sml = 1'b0;
    if_def.pix_en = 1'b1;
    if_sml.pix_en = 1'b0;

    // ---------------- default geometry: one line ----------------
    tick();
    check("def_rst.hpos",       if_def.hpos,        0);
    check("def_rst.vpos",       if_def.vpos,        0);
    check("def_rst.hsync",      if_def.hsync,       1);
    check("def_rst.vsync",      if_def.vsync,       1);
    check("def_rst.visible",    if_def.visible,     1);
    check("def_rst.line_start", if_def.line_start,  1);
`ifdef VGA_FRAME_COUNT_EN
    check("def_rst.frame_start", if_def.frame_start, 1);
`else
    check("def_rst.frame_start", if_def.frame_start, 0);
`endif
    check("def_rst.frame_count", if_def.frame_count, 0);

    rst_n_def = 1'b1;
    hs_low = 0; hs_first = -1; vis_low = 0; vs_low = 0;
    for (int i = 1; i <= 800; i++) begin
      tick();
      check("def_line.hpos",       if_def.hpos,       i % 800);
      check("def_line.vpos",       if_def.vpos,       i / 800);
      check("def_line.line_start", if_def.line_start, (i % 800) == 0);
      if (!if_def.hsync) begin
        if (hs_first < 0) hs_first = int'(if_def.hpos);
        hs_low++;
      end
      if (!if_def.visible) vis_low++;
      if (!if_def.vsync) vs_low++;
    end
    check("def_line.hsync_low_cycles",   hs_low,   96);
    check("def_line.hsync_first_hpos",   hs_first, 656);
    check("def_line.visible_low_cycles", vis_low,  160);
    check("def_line.vsync_low_cycles",   vs_low,   0);
    check("def_line.visible_at_next",    if_def.visible, 1);
    if_def.pix_en = 1'b0;

    // ---------------- reduced geometry: table vectors ----------------
    //          rst pe  ncyc  h   v  hs vs vis ls fc
    vecs[0]  = '{0, 1,  1,    0,  0, 1, 1, 1,  1, 0};
    vecs[1]  = '{1, 1,  1,    1,  0, 1, 1, 1,  0, 0};
    vecs[2]  = '{1, 0,  1,    1,  0, 1, 1, 1,  0, 0};
    vecs[3]  = '{1, 0,  1,    1,  0, 1, 1, 1,  0, 0};
    vecs[4]  = '{1, 1,  1,    2,  0, 1, 1, 1,  0, 0};
    vecs[5]  = '{1, 1,  5,    7,  0, 1, 1, 1,  0, 0};
    vecs[6]  = '{1, 1,  1,    8,  0, 1, 1, 0,  0, 0};
    vecs[7]  = '{1, 1,  2,   10,  0, 0, 1, 0,  0, 0};
    vecs[8]  = '{1, 1,  2,   12,  0, 0, 1, 0,  0, 0};
    vecs[9]  = '{1, 1,  1,   13,  0, 1, 1, 0,  0, 0};
    vecs[10] = '{1, 1,  2,   15,  0, 1, 1, 0,  0, 0};
    vecs[11] = '{1, 1,  1,    0,  1, 1, 1, 1,  1, 0};
    vecs[12] = '{1, 1,  64,   0,  5, 1, 0, 0,  1, 0};
    vecs[13] = '{1, 0,  3,    0,  5, 1, 0, 0,  1, 0};
    vecs[14] = '{1, 1,  31,  15,  6, 1, 0, 0,  0, 0};
    vecs[15] = '{1, 1,  1,    0,  7, 1, 1, 0,  1, 0};
    vecs[16] = '{1, 1,  15,  15,  7, 1, 1, 0,  0, 0};
    vecs[17] = '{1, 1,  1,    0,  0, 1, 1, 1,  1, 1};
    vecs[18] = '{1, 1,  50,   2,  3, 1, 1, 1,  0, 1};
    vecs[19] = '{0, 1,  1,    0,  0, 1, 1, 1,  1, 0};
    vecs[20] = '{0, 0,  1,    0,  0, 1, 1, 1,  1, 0};
    vecs[21] = '{1, 1,  1,    1,  0, 1, 1, 1,  0, 0};

    for (int k = 0; k < 22; k++) begin
      rst_n_sml     = vecs[k].rst_n;
      if_sml.pix_en = vecs[k].pe;
      repeat (vecs[k].ncyc) tick();
      e.h   = vecs[k].h;
      e.v   = vecs[k].v;
      e.hs  = vecs[k].hs;
      e.vs  = vecs[k].vs;
      e.vis = vecs[k].vis;
      e.ls  = vecs[k].ls;
`ifdef VGA_FRAME_COUNT_EN
      e.fs  = (vecs[k].h == 0) && (vecs[k].v == 0);
      e.fc  = vecs[k].fc;
`else
      e.fs  = 1'b0;
      e.fc  = 0;
`endif
      compare_sml($sformatf("vec%0d", k), e);
    end

    // ---------------- reduced geometry: randomized vs model ----------------
    rst_n_sml     = 1'b0;
    if_sml.pix_en = 1'b1;
    tick();
    n = 0;
    compare_sml("rand_rst", model(n));
    for (int c = 0; c < 2000; c++) begin
      rst_n_sml     = ($urandom_range(0, 199) != 0);
      if_sml.pix_en = $urandom_range(0, 3) != 0;
      tick();
      if (!rst_n_sml)         n = 0;
      else if (if_sml.pix_en) n++;
      compare_sml("rand", model(n));
    end

    // ---------------- reduced geometry: frame counter wrap ----------------
    rst_n_sml     = 1'b0;
    if_sml.pix_en = 1'b1;
    tick();
    rst_n_sml = 1'b1;
    repeat (255 * HT * VT) tick();
    compare_sml("wrap_255", model(255 * HT * VT));
    repeat (HT * VT - 1) tick();
    compare_sml("wrap_last", model(256 * HT * VT - 1));
    tick();
    compare_sml("wrap_zero", model(256 * HT * VT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
